// File: rtl/piso_serializer_if.sv
// Handshake and serial-output bundle for piso_serializer.
// Latency: n/a (wires only).
// Backpressure: din_ready from the slave gates acceptance of din/din_valid.
interface piso_serializer_if #(
  parameter int WIDTH = 8
);
  logic [WIDTH-1:0] din;
  logic             din_valid;
  logic             din_ready;
  logic             bit_en;
  logic             sout;
  logic             sout_valid;
  logic             done;

  // Producer / bit-clock side
  modport master (
    output din, din_valid, bit_en,
    input  din_ready, sout, sout_valid, done
  );

  // Serializer side
  modport slave (
    input  din, din_valid, bit_en,
    output din_ready, sout, sout_valid, done
  );
endinterface

// File: rtl/piso_serializer.sv
// Parallel-in serial-out serializer; optional even-parity trailer via PISO_SERIALIZER_PARITY_EN.
// Latency: first bit on sout the cycle after acceptance; each bit held until bit_en.
// Backpressure: din_ready only in IDLE (and never during rst); a word needs one IDLE cycle between frames.
module piso_serializer #(
  parameter int WIDTH     = 8,
  parameter bit LSB_FIRST = 1'b1
) (
  input  logic               clk,
  input  logic               rst,
  piso_serializer_if.slave   bus
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

`ifdef PISO_SERIALIZER_PARITY_EN
  typedef enum logic [1:0] {IDLE, SHIFT, PARITY} state_t;
`else
  typedef enum logic [1:0] {IDLE, SHIFT} state_t;
`endif

  state_t           state_q, state_d;
  logic [WIDTH-1:0] sr_q, sr_d;      // bits still to be sent, next one at the output end
  logic [CW-1:0]    cnt_q, cnt_d;    // index of the data bit currently on sout
  logic             sout_q, sout_d;
  logic             vld_q, vld_d;
  logic             done_q, done_d;
`ifdef PISO_SERIALIZER_PARITY_EN
  logic             par_q, par_d;    // even parity of the loaded word
`endif

  // Next-state, shift and output-register logic
  always_comb begin
    state_d = state_q;
    sr_d    = sr_q;
    cnt_d   = cnt_q;
    sout_d  = sout_q;
    vld_d   = vld_q;
    done_d  = 1'b0;
`ifdef PISO_SERIALIZER_PARITY_EN
    par_d   = par_q;
`endif
    case (state_q)
      IDLE: begin
        if (bus.din_valid) begin
          // First bit goes straight to the output register; the rest wait in sr.
          state_d = SHIFT;
          cnt_d   = '0;
          vld_d   = 1'b1;
          sout_d  = LSB_FIRST ? bus.din[0] : bus.din[WIDTH-1];
          sr_d    = LSB_FIRST ? (bus.din >> 1) : (bus.din << 1);
`ifdef PISO_SERIALIZER_PARITY_EN
          par_d   = ^bus.din;
`endif
        end
      end
      SHIFT: begin
        if (bus.bit_en) begin
          if (cnt_q == CW'(WIDTH - 1)) begin
`ifdef PISO_SERIALIZER_PARITY_EN
            state_d = PARITY;
            sout_d  = par_q;
            vld_d   = 1'b1;
`else
            state_d = IDLE;
            sout_d  = 1'b0;
            vld_d   = 1'b0;
            done_d  = 1'b1;
`endif
          end else begin
            cnt_d  = cnt_q + 1'b1;
            sout_d = LSB_FIRST ? sr_q[0] : sr_q[WIDTH-1];
            sr_d   = LSB_FIRST ? (sr_q >> 1) : (sr_q << 1);
          end
        end
      end
`ifdef PISO_SERIALIZER_PARITY_EN
      PARITY: begin
        if (bus.bit_en) begin
          state_d = IDLE;
          sout_d  = 1'b0;
          vld_d   = 1'b0;
          done_d  = 1'b1;
        end
      end
`endif
      default: begin
        state_d = IDLE;
        sout_d  = 1'b0;
        vld_d   = 1'b0;
      end
    endcase
  end

  // State registers; synchronous reset overrides any transfer or bit_en
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      sr_q    <= '0;
      cnt_q   <= '0;
      sout_q  <= 1'b0;
      vld_q   <= 1'b0;
      done_q  <= 1'b0;
`ifdef PISO_SERIALIZER_PARITY_EN
      par_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      sr_q    <= sr_d;
      cnt_q   <= cnt_d;
      sout_q  <= sout_d;
      vld_q   <= vld_d;
      done_q  <= done_d;
`ifdef PISO_SERIALIZER_PARITY_EN
      par_q   <= par_d;
`endif
    end
  end

  // Ready is withheld during reset so a word presented with rst is never taken.
  assign bus.din_ready  = (state_q == IDLE) && !rst;
  assign bus.sout       = sout_q;
  assign bus.sout_valid = vld_q;
  assign bus.done       = done_q;

endmodule

// File: doc/piso_serializer.md
PISO_SERIALIZER -- requirements
Module: piso_serializer

Interface
REQ-001 Parameter WIDTH, default 8: data word width in bits, legal range 1 to 32.
REQ-002 Parameter LSB_FIRST, default 1: 1 shifts bit 0 first; 0 shifts bit WIDTH-1 first.
REQ-003 The block SHALL use one clock and a synchronous, active-high reset.
REQ-004 Port clk, input, 1 bit: single clock; all state changes on its rising edge.
REQ-005 Port rst, input, 1 bit: synchronous active-high reset.
REQ-006 Port din, input, WIDTH bits: parallel word to serialize.
REQ-007 Port din_valid, input, 1 bit: din is valid this cycle.
REQ-008 Port din_ready, output, 1 bit: the block accepts a word this cycle.
REQ-009 Port bit_en, input, 1 bit: bit-rate strobe that advances the current serial bit.
REQ-010 Port sout, output, 1 bit: serial data, registered.
REQ-011 Port sout_valid, output, 1 bit: sout carries a frame bit, registered.
REQ-012 Port done, output, 1 bit: one-cycle pulse after the last frame bit completes, registered.

Function
REQ-013 The block SHALL implement the FSM states IDLE and SHIFT, plus PARITY when the REQ-027 macro is defined.
REQ-014 In IDLE, din_ready SHALL be 1. In every other state, and in any cycle where rst=1, din_ready SHALL be 0.
REQ-015 A transfer SHALL occur when din_valid=1 and din_ready=1. The word is then loaded into the shift register, the bit counter is cleared and the FSM moves to SHIFT.
REQ-016 If a transfer occurs in cycle N, the first bit SHALL appear on sout with sout_valid=1 in cycle N+1.
REQ-017 Each bit SHALL hold on sout until a cycle in which bit_en=1 while sout_valid=1. The next bit SHALL appear in the following cycle.
REQ-018 bit_en SHALL be ignored in IDLE. din and din_valid SHALL be ignored outside IDLE.
REQ-019 When bit_en=1 on data bit WIDTH-1, the FSM SHALL go to IDLE, or to PARITY when that state is compiled in.
REQ-020 On that transition to IDLE, sout_valid SHALL fall and done SHALL pulse high for exactly one cycle.
REQ-021 sout SHALL return to 0 whenever sout_valid=0.
REQ-022 The minimum spacing between words SHALL be one IDLE cycle; back-to-back acceptance without an IDLE cycle is not supported.
REQ-023 With WIDTH=1, the frame SHALL be a single data bit, plus parity when enabled.

Reset
REQ-024 While rst=1 at a clock edge, the FSM SHALL enter IDLE and the block SHALL drive sout=0, sout_valid=0, done=0, and clear the shift register and counter.
REQ-025 A reset asserted mid-frame SHALL abort the frame. From the next cycle sout_valid=0, no done pulse is issued for the aborted word, and din_ready=1 in the first cycle with rst=0.
REQ-026 Reset SHALL take priority over a simultaneous transfer or bit_en.

Configuration
REQ-027 Parity is controlled by the macro PISO_SERIALIZER_PARITY_EN.
REQ-028 With the macro defined, state PARITY SHALL follow the last data bit and drive sout to the even-parity bit (XOR of the loaded word) with sout_valid=1. It holds until bit_en=1, then the FSM goes to IDLE with done pulsed.
REQ-029 With the macro undefined, no PARITY state or parity logic SHALL exist and the frame SHALL be exactly WIDTH bits.

Verification
All scenarios use WIDTH=8.
REQ-030 Scenario 1: reset; LSB_FIRST=1; din=8'hA5 accepted in cycle 0; bit_en=1 constantly.
- Expected: sout=1,0,1,0,0,1,0,1 in cycles 1-8.
- Macro undefined: done=1 in cycle 9.
- Macro defined: parity bit 0 in cycle 9 and done=1 in cycle 10.
REQ-031 Scenario 2: LSB_FIRST=0; din=8'h80; bit_en high every 3rd cycle.
- Expected: sout=1 held for 3 cycles, then 0 for 21 cycles.
- Macro defined: a parity bit of 1 follows.
- sout_valid is continuous throughout the frame.
REQ-032 Scenario 3: din_valid held 1 with din=8'h3C during the frame of Scenario 1.
- Expected: din_ready=0 throughout the frame.
- Expected: the word 8'h3C is accepted only in the first IDLE cycle after done.
REQ-033 Scenario 4: rst=1 for one cycle after the 4th bit of a frame.
- Expected: sout_valid=0 and sout=0 from the next cycle.
- Expected: no done pulse for the aborted frame.
- Expected: a new word 8'h0F is serialized correctly afterwards.
REQ-034 Scenario 5: rst=1 coinciding with din_valid=1.
- Expected: no transfer occurs.
- Expected: din_ready=0 in that cycle and sout_valid stays 0.
